// File: rtl/operand_fwd_mux_if.sv
// Operand forwarding bus: instruction sources, EX/MEM and MEM/WB writer
// info, pipeline control, and the registered forwarded operands.
interface operand_fwd_mux_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [WIDTH-1:0]  rs_data;
  logic [WIDTH-1:0]  rt_data;
  logic              exmem_wr_en;
  logic              exmem_is_load;
  logic [ADDR_W-1:0] exmem_rd;
  logic [WIDTH-1:0]  exmem_data;
  logic              memwb_wr_en;
  logic [ADDR_W-1:0] memwb_rd;
  logic [WIDTH-1:0]  memwb_data;
  logic              stall_in;
  logic              flush;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [1:0]        sel_a;
  logic [1:0]        sel_b;
  logic              out_valid;
  logic              hazard_stall;
  logic [15:0]       hazard_cnt;

  // upstream side: presents instructions and writer state
  modport master (
    output in_valid, rs_addr, rt_addr, rs_data, rt_data,
           exmem_wr_en, exmem_is_load, exmem_rd, exmem_data,
           memwb_wr_en, memwb_rd, memwb_data, stall_in, flush,
    input  op_a, op_b, sel_a, sel_b, out_valid, hazard_stall, hazard_cnt
  );

  // forwarding unit side
  modport slave (
    input  in_valid, rs_addr, rt_addr, rs_data, rt_data,
           exmem_wr_en, exmem_is_load, exmem_rd, exmem_data,
           memwb_wr_en, memwb_rd, memwb_data, stall_in, flush,
    output op_a, op_b, sel_a, sel_b, out_valid, hazard_stall, hazard_cnt
  );
endinterface

// File: rtl/operand_fwd_mux.sv
// Operand forwarding mux with load-use hazard bubble insertion.
// Per-operand source selection lives in operand_fwd_sel; the top
// registers the selected operands and runs the RUN/WAIT bubble FSM.

// One operand's source pick: EX/MEM (non-load) > MEM/WB > register file.
// Register 0 is never forwarded.
module operand_fwd_sel #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_rf_data,
  input  logic              i_exmem_wr_en,
  input  logic              i_exmem_is_load,
  input  logic [ADDR_W-1:0] i_exmem_rd,
  input  logic [WIDTH-1:0]  i_exmem_data,
  input  logic              i_memwb_wr_en,
  input  logic [ADDR_W-1:0] i_memwb_rd,
  input  logic [WIDTH-1:0]  i_memwb_data,
  output logic [WIDTH-1:0]  o_data,
  output logic [1:0]        o_sel
);
  logic w_ex_hit;
  logic w_mw_hit;

  // a load in EX/MEM has no data yet, so it is never a forwarding source
  assign w_ex_hit = i_exmem_wr_en & ~i_exmem_is_load &
                    (i_exmem_rd != '0) & (i_exmem_rd == i_addr);
  assign w_mw_hit = i_memwb_wr_en & (i_memwb_rd != '0) & (i_memwb_rd == i_addr);

  // priority select, youngest writer first
  always_comb begin
    o_sel  = 2'b00;
    o_data = i_rf_data;
    if (w_ex_hit) begin
      o_sel  = 2'b10;
      o_data = i_exmem_data;
    end else if (w_mw_hit) begin
      o_sel  = 2'b01;
      o_data = i_memwb_data;
    end
  end
endmodule

// LOAD_LAT must stay within 1..7 so LOAD_LAT-1 fits the 3-bit wait counter.
module operand_fwd_mux #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  operand_fwd_mux_if.slave  bus
);
  localparam int           NUM_OPS   = 2;
  localparam logic [2:0]   WAIT_INIT = 3'(LOAD_LAT - 1);
  localparam bit           MULTI_LAT = (LOAD_LAT > 1);

  typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t                          r_state;
  logic [2:0]                      r_wait_cnt;
  logic [NUM_OPS-1:0][WIDTH-1:0]   r_op;
  logic [NUM_OPS-1:0][1:0]         r_sel;
  logic                            r_out_valid;
  logic [15:0]                     r_hazard_cnt;

  logic [NUM_OPS-1:0][ADDR_W-1:0]  w_src_addr;
  logic [NUM_OPS-1:0][WIDTH-1:0]   w_rf_data;
  logic [NUM_OPS-1:0][WIDTH-1:0]   w_fwd_data;
  logic [NUM_OPS-1:0][1:0]         w_fwd_sel;
  logic                            w_load_use;
  logic                            w_hazard;

  // lane 0 = rs -> op_a, lane 1 = rt -> op_b
  assign w_src_addr = {bus.rt_addr, bus.rs_addr};
  assign w_rf_data  = {bus.rt_data, bus.rs_data};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_lane
    operand_fwd_sel #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_sel (
      .i_addr          (w_src_addr[g]),
      .i_rf_data       (w_rf_data[g]),
      .i_exmem_wr_en   (bus.exmem_wr_en),
      .i_exmem_is_load (bus.exmem_is_load),
      .i_exmem_rd      (bus.exmem_rd),
      .i_exmem_data    (bus.exmem_data),
      .i_memwb_wr_en   (bus.memwb_wr_en),
      .i_memwb_rd      (bus.memwb_rd),
      .i_memwb_data    (bus.memwb_data),
      .o_data          (w_fwd_data[g]),
      .o_sel           (w_fwd_sel[g])
    );
  end

  assign w_load_use = bus.in_valid & bus.exmem_wr_en & bus.exmem_is_load &
                      (bus.exmem_rd != '0) &
                      ((bus.exmem_rd == bus.rs_addr) | (bus.exmem_rd == bus.rt_addr));

  // detection is masked while bubbles drain so one load gives LOAD_LAT bubbles
  assign w_hazard = (r_state == ST_RUN) & w_load_use;

  // upstream holds whenever we will not consume the presented instruction;
  // a flush kills everything, so no hold is needed then
  assign bus.hazard_stall = ~bus.flush &
                            (bus.stall_in | (r_state == ST_WAIT) | w_hazard);

  // operand registers, bubble FSM and hazard counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_wait_cnt   <= '0;
      r_op         <= '0;
      r_sel        <= '0;
      r_out_valid  <= 1'b0;
      r_hazard_cnt <= '0;
    end else if (bus.flush) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_out_valid <= 1'b0;
    end else if (!bus.stall_in) begin
      case (r_state)
        ST_RUN: begin
          if (w_hazard) begin
            r_out_valid <= 1'b0;
            r_wait_cnt  <= WAIT_INIT;
            r_state     <= MULTI_LAT ? ST_WAIT : ST_RUN;
            if (r_hazard_cnt != 16'hFFFF)
              r_hazard_cnt <= r_hazard_cnt + 16'd1;
          end else begin
            r_out_valid <= bus.in_valid;
            // operands only move with a real instruction
            if (bus.in_valid) begin
              r_op  <= w_fwd_data;
              r_sel <= w_fwd_sel;
            end
          end
        end
        ST_WAIT: begin
          r_out_valid <= 1'b0;
          // leave on the cycle the counter reaches zero
          if (r_wait_cnt <= 3'd1) begin
            r_wait_cnt <= '0;
            r_state    <= ST_RUN;
          end else begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
          end
        end
      endcase
    end
  end

  assign bus.op_a       = r_op[0];
  assign bus.op_b       = r_op[1];
  assign bus.sel_a      = r_sel[0];
  assign bus.sel_b      = r_sel[1];
  assign bus.out_valid  = r_out_valid;
  assign bus.hazard_cnt = r_hazard_cnt;
endmodule

// File: doc/operand_fwd_mux.md
OPERAND_FWD_MUX -- requirements
Module: operand_fwd_mux

Interface
REQ-001 Parameter WIDTH, default 32: operand and data width in bits.
REQ-002 Parameter ADDR_W, default 5: register address width.
REQ-003 Parameter LOAD_LAT, default 1, legal range 1..7: bubble cycles inserted on a load-use hazard.
REQ-004 Port clk  input  1: single clock, all state updates on rising edge.
REQ-005 Port rst  input  1: reset, synchronous, active-high.
REQ-006 Port in_valid  input  1: an instruction is presented for operand capture.
REQ-007 Ports rs_addr, rt_addr  input  ADDR_W: source register addresses.
REQ-008 Ports rs_data, rt_data  input  WIDTH: register-file read values.
REQ-009 Ports exmem_wr_en, exmem_is_load  input  1; exmem_rd  input  ADDR_W; exmem_data  input  WIDTH: EX/MEM writer information.
REQ-010 Ports memwb_wr_en  input  1; memwb_rd  input  ADDR_W; memwb_data  input  WIDTH: MEM/WB writer information.
REQ-011 Ports stall_in, flush  input  1: downstream hold request and pipeline kill.
REQ-012 Ports op_a, op_b  output  WIDTH: registered forwarded operands.
REQ-013 Ports sel_a, sel_b  output  2: registered source select, 00 regfile, 01 MEM/WB, 10 EX/MEM.
REQ-014 Port out_valid  output  1: registered, op_a/op_b hold a real instruction.
REQ-015 Port hazard_stall  output  1: combinational, upstream SHALL hold its inputs while high.
REQ-016 Port hazard_cnt  output  16: count of load-use hazard events, saturating at 16'hFFFF.

Function
REQ-017 Each operand SHALL select EX/MEM data when exmem_wr_en=1, exmem_rd!=0, exmem_rd equals the source address, and exmem_is_load=0.
REQ-018 Otherwise each operand SHALL select MEM/WB data when memwb_wr_en=1, memwb_rd!=0, and memwb_rd equals the source address.
REQ-019 Otherwise each operand SHALL select the register-file value; register 0 SHALL never be forwarded.
REQ-020 A load-use hazard SHALL exist when in_valid=1, exmem_wr_en=1, exmem_is_load=1, exmem_rd!=0, and exmem_rd equals rs_addr or rt_addr.
REQ-021 The FSM SHALL have states RUN and WAIT, plus a 3-bit down-counter wait_cnt.
REQ-022 In RUN with a hazard and stall_in=0 and flush=0, the block SHALL assert hazard_stall, load out_valid=0, set wait_cnt=LOAD_LAT-1, increment hazard_cnt, and enter WAIT if LOAD_LAT>1.
REQ-023 If LOAD_LAT=1, the block SHALL stay in RUN after a hazard.
REQ-024 In WAIT, hazard_stall SHALL be 1 and out_valid SHALL load 0 each cycle; wait_cnt SHALL decrement, and the FSM SHALL return to RUN when wait_cnt=0.
REQ-025 Hazard detection SHALL be suppressed in WAIT, so a single hazard yields exactly LOAD_LAT bubble cycles.
REQ-026 In RUN without a hazard, stall_in=0 and flush=0, op_a/op_b/sel_a/sel_b SHALL capture the selected values and out_valid SHALL capture in_valid, giving 1-cycle latency.
REQ-027 With stall_in=1 and flush=0, all output registers, the FSM, and wait_cnt SHALL hold; hazard_stall SHALL be 1 and hazard_cnt SHALL not change.
REQ-028 With flush=1, out_valid SHALL load 0, the FSM SHALL return to RUN, and wait_cnt SHALL clear; flush overrides stall_in and hazard.
REQ-029 When out_valid loads 0, op_a, op_b, sel_a, and sel_b SHALL hold their previous values.
REQ-030 hazard_cnt SHALL saturate and never wrap.

Reset
REQ-031 On clk rise with rst=1, op_a, op_b, sel_a, sel_b, out_valid, hazard_cnt, and wait_cnt SHALL be 0 and the FSM SHALL be RUN; rst overrides all other inputs.
REQ-032 hazard_stall SHALL be 0 in the cycle after reset unless a hazard is presented.
REQ-033 Reset asserted in WAIT SHALL abort the wait with no further bubbles.

Verification
REQ-034 rs_addr=3, exmem_wr_en=1, exmem_rd=3, exmem_data=0xAA, memwb_rd=3, memwb_data=0xBB -> next cycle op_a=0xAA, sel_a=10, out_valid=1.
REQ-035 rs_addr=0, exmem_wr_en=1, exmem_rd=0, rs_data=0 -> sel_a=00, op_a=0.
REQ-036 LOAD_LAT=3, load with exmem_rd=5, rt_addr=5 -> hazard_stall high for 3 cycles, out_valid=0 for 3 cycles, hazard_cnt=1; the held instruction then issues with sel_b=01.
REQ-037 During a hazard, stall_in=1 for 2 cycles -> FSM, wait_cnt, and hazard_cnt are frozen and the total bubble count stays at 3.
REQ-038 Simultaneous stall_in=1 and flush=1 in WAIT -> next cycle out_valid=0, FSM=RUN, hazard_stall=0.
REQ-039 Force hazard_cnt=16'hFFFE and present 3 hazards -> hazard_cnt=16'hFFFF.
